cic_interpolator: RTL and testbench

- Multirate CIC interpolator, the transmit-side counterpart of cic_decimator: takes low-rate signed samples and produces signed samples at the full cic_clk rate, interpolating by R.
- Structure: N comb stages at the input rate, zero-stuffing by R, then N integrator stages at the clock rate.
- Sits between the baseband sample source and the high-rate datapath; shares cic_clk with the decimator.

---
 rtl/cic_pkg.sv | 21 ++
 rtl/cic_integ_stage.sv | 11 +
 rtl/cic_interpolator.sv | 80 ++++++++
 tb/tb_cic_interpolator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: shared CIC defaults, clog2 and growth/width helpers for cic_interpolator and cic_decimator
package cic_pkg;
  localparam int CIC_R = 8;
  localparam int CIC_N = 3;
  localparam int CIC_M = 1;
  localparam int CIC_DIN_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int growth(input int r, input int n, input int m);
    return n * clog2(r * m) - clog2(r);
  endfunction
  function automatic int dout_w(input int din_w, input int r, input int n, input int m);
    return din_w + growth(r, n, m);
  endfunction
  localparam int CIC_G = growth(CIC_R, CIC_N, CIC_M);
  localparam int CIC_DOUT_W = dout_w(CIC_DIN_W, CIC_R, CIC_N, CIC_M);
endpackage

// File: rtl/cic_integ_stage.sv
// cic_integ_stage: W-wide wrapping accumulator (clk, rst sync clear, in_d addend, acc registered sum)
module cic_integ_stage #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk) acc <= rst ? '0 : acc + in_d;
endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: R-fold CIC interpolator (cic_clk/cic_rst, cic_din+vld/rdy in at 1/R, cic_dout+vld every cycle, sticky cic_unf); CIC_INTERP_GAIN_NORM_EN selects unity-gain rounded output
module cic_interpolator import cic_pkg::*; #(
  parameter int R = CIC_R,
  parameter int N = CIC_N,
  parameter int M = CIC_M,
  parameter int DIN_W = CIC_DIN_W,
  parameter int DOUT_W = CIC_DOUT_W
) (
  input  logic              cic_clk,
  input  logic              cic_rst,
  input  logic [DIN_W-1:0]  cic_din,
  input  logic              cic_din_vld,
  output logic              cic_din_rdy,
  output logic [DOUT_W-1:0] cic_dout,
  output logic              cic_dout_vld,
  output logic              cic_unf
);
  localparam int G = growth(R, N, M);
  localparam int PW = clog2(R);
  if (DOUT_W != dout_w(DIN_W, R, N, M)) begin : g_bad_width
    $error("cic_interpolator: DOUT_W does not match DIN_W + growth");
  end
  logic [PW-1:0] phase;
  logic started;
  logic ph0, acc_in, tick;
  logic [N:0] vsr;
  logic [DOUT_W-1:0] up, out_v;
  logic signed [DOUT_W-1:0] c [N+1];
  logic signed [DOUT_W-1:0] dl [N][M];
  logic [DOUT_W-1:0] a [N+1];
  assign ph0 = phase == '0;
  assign cic_din_rdy = ph0;
  assign acc_in = ph0 & cic_din_vld;
  assign tick = ph0 & (cic_din_vld | started);
  assign c[0] = acc_in ? DOUT_W'(signed'(cic_din)) : '0;
  for (genvar k = 0; k < N; k++) begin : g_comb
    assign c[k+1] = c[k] - dl[k][M-1];
  end
  always_ff @(posedge cic_clk)
    if (cic_rst) dl <= '{default: '0};
    else if (tick)
      for (int k = 0; k < N; k++) begin
        dl[k][0] <= c[k];
        for (int j = 1; j < M; j++) dl[k][j] <= dl[k][j-1];
      end
  always_ff @(posedge cic_clk)
    if (cic_rst) begin
      phase <= '0;
      started <= 1'b0;
      cic_unf <= 1'b0;
      up <= '0;
      vsr <= '0;
      cic_dout <= '0;
    end else begin
      phase <= phase + 1'b1;
      started <= started | acc_in;
      cic_unf <= cic_unf | (ph0 & ~cic_din_vld & started);
      up <= tick ? c[N] : '0;
      vsr <= {vsr[N-1:0], started};
      cic_dout <= out_v;
    end
  assign cic_dout_vld = vsr[N];
  assign a[0] = up;
  for (genvar k = 0; k < N; k++) begin : g_integ
    cic_integ_stage #(.W(DOUT_W)) u_integ (
      .clk (cic_clk),
      .rst (cic_rst),
      .in_d(a[k]),
      .acc (a[k+1])
    );
  end
`ifdef CIC_INTERP_GAIN_NORM_EN
  localparam logic [DOUT_W-1:0] rnd = DOUT_W'((2 ** G) / 2);
  logic signed [DOUT_W-1:0] biased;
  assign biased = a[N] + rnd;
  assign out_v = biased >>> G;
`else
  assign out_v = a[N];
`endif
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed tests with an impulse-response convolution model of cic_interpolator
module tb_cic_interpolator;
  localparam int R = 8;
  localparam int N = 3;
  localparam int M = 1;
  localparam int DIN_W = 16;
  localparam int DOUT_W = 22;
  localparam int G = 6;
  localparam int L = (R * M - 1) * N + 1;
  localparam int LAT = N + 2;
  typedef struct {int t; longint v;} tk_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [DIN_W-1:0] din = '0;
  logic rdy, dvld, unf;
  logic [DOUT_W-1:0] dout;
  int compared = 0;
  int mismatched = 0;
  longint h [L];
  int lit [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};
  tk_t q [$];
  int cyc = 0;
  int m_phase = 0;
  int m_first = -1;
  bit m_started = 0;
  bit m_unf = 0;
  bit inited = 0;
  cic_interpolator #(.R(R), .N(N), .M(M), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
    .cic_clk     (clk),
    .cic_rst     (rst),
    .cic_din     (din),
    .cic_din_vld (vld),
    .cic_din_rdy (rdy),
    .cic_dout    (dout),
    .cic_dout_vld(dvld),
    .cic_unf     (unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin : cmp
    longint s;
    int d;
    logic [DOUT_W-1:0] e;
    logic signed [DOUT_W-1:0] es;
    if (inited) begin
      s = 0;
      foreach (q[i]) begin
        d = cyc - q[i].t - LAT;
        if (d >= 0 && d < L) s += q[i].v * h[d];
      end
      e = s[DOUT_W-1:0];
`ifdef CIC_INTERP_GAIN_NORM_EN
      es = e + DOUT_W'((2 ** G) / 2);
      e = es >>> G;
`else
      es = '0;
`endif
      chk("rdy", rdy, m_phase == 0);
      chk("dout", dout, e);
      chk("dout_vld", dvld, m_first >= 0 && cyc >= m_first + LAT);
      chk("unf", unf, m_unf);
    end
    if (rst) begin
      q.delete();
      m_phase = 0;
      m_started = 0;
      m_unf = 0;
      m_first = -1;
      inited = 1;
    end else begin
      if (m_phase == 0 && (vld || m_started)) q.push_back('{t: cyc, v: vld ? longint'($signed(din)) : 0});
      if (m_phase == 0 && !vld && m_started) m_unf = 1;
      if (m_phase == 0 && vld && !m_started) begin
        m_started = 1;
        m_first = cyc;
      end
      m_phase = (m_phase + 1) % R;
      while (q.size() > 0 && cyc - q[0].t > L + LAT) void'(q.pop_front());
    end
    cyc++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    repeat (n) step();
    rst = 1'b0;
  endtask
  task automatic send(input logic [DIN_W-1:0] v, input logic valid);
    din = v;
    vld = valid;
    repeat (R) step();
  endtask
  initial begin
    longint t [L];
    int len;
    int isum;
    h = '{default: 0};
    h[0] = 1;
    len = 1;
    repeat (N) begin
      t = '{default: 0};
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R * M; j++) t[i+j] += h[i];
      len += R * M - 1;
      h = t;
    end
    for (int j = 0; j < 22; j += 7) chk("h_pin", h[j], lit[j]);
    do_reset(4);
    for (int k = 0; k < 20; k++) begin
      chk("rst_rdy", rdy, (k % R) == 0);
      chk("rst_dout", dout, 0);
      chk("rst_vld", dvld, 0);
      chk("rst_unf", unf, 0);
      step();
    end
    do_reset(2);
    vld = 1'b1;
    isum = 0;
    for (int k = 0; k < 40; k++) begin
      din = k < R ? DIN_W'(1) : '0;
`ifndef CIC_INTERP_GAIN_NORM_EN
      if (k >= LAT && k < LAT + 24) begin
        chk("impulse", dout, k - LAT < 22 ? lit[k-LAT] : 0);
        isum += int'(dout);
      end
`endif
      step();
    end
`ifndef CIC_INTERP_GAIN_NORM_EN
    chk("impulse_sum", isum, 512);
`endif
    do_reset(2);
    din = DIN_W'(1000);
    vld = 1'b1;
    repeat (40) step();
    for (int k = 0; k < 8; k++) begin
`ifdef CIC_INTERP_GAIN_NORM_EN
      chk("dc", dout, 1000);
`else
      chk("dc", dout, 64000);
`endif
      step();
    end
    do_reset(2);
    for (int i = 0; i < 200; i++) send(i % 2 ? 16'h8000 : 16'h7fff, 1'b1);
    chk("ext_vld", dvld, 1);
    do_reset(2);
    for (int i = 0; i < 10; i++) send(DIN_W'(i * 300 - 1000), 1'b1);
    chk("unf_pre", unf, 0);
    vld = 1'b0;
    din = '0;
    step();
    chk("unf_rise", unf, 1);
    chk("unf_dvld", dvld, 1);
    repeat (R - 1) step();
    for (int i = 0; i < 3; i++) send(DIN_W'(200), 1'b1);
    chk("unf_sticky", unf, 1);
    chk("unf_dvld2", dvld, 1);
    din = DIN_W'(1000);
    repeat (40) step();
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mrst_dout", dout, 0);
    chk("mrst_vld", dvld, 0);
    rst = 1'b0;
    vld = 1'b0;
    repeat (R) step();
    vld = 1'b1;
    din = DIN_W'(500);
    for (int k = 0; k < LAT + 3; k++) begin
      chk("restart_vld", dvld, k >= LAT);
      step();
    end
    chk("restart_unf", unf, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
